bcd_seg_display: RTL and testbench
==================================

// Module: bcd_seg_display
// PURPOSE
//   Sequential binary-to-decimal converter driving DIGITS 7-segment displays.
//   Parametrised successor of the combinational 4-bit SW->HEX1/HEX0 decimal display.
//   Converts any WIDTH-bit value via iterative double-dabble (one bit per clock).
//   Uses a START/BUSY/DONE handshake, optional leading-zero blanking and an
//   overflow indication.
//   Sits between board inputs (SW, or a counter) and the HEX0..HEX5 pins.
// PARAMETERS
//   WIDTH     10  binary input width, 1..20
//   DIGITS    4   displayed digits, 1..6; digit 0 is least significant
//   BLANK_LZ  1   1 = blank leading zeros (digit 0 always shown); 0 = show all zeros
// PORTS
//   MAX10_CLK1_50  in   1           system clock, 50 MHz, rising edge
//   RESET_N        in   1           async active-low reset (top level drives it from KEY[0])
//   START          in   1           request conversion of BIN; sampled in IDLE only
//   BIN            in   WIDTH       unsigned value; latched on the accepted START cycle
//   BUSY           out  1           high from the cycle after accept until DONE
//   DONE           out  1           one-cycle pulse; HEX/OVERFLOW valid from this cycle
//   OVERFLOW       out  1           last result needs more than DIGITS digits
//   HEX            out  8*DIGITS    active-low segments, per digit {dp,g,f,e,d,c,b,a};
//                                   HEX[8k+7:8k] = digit k
// BEHAVIOUR
//   Reset (async assert, sync release):
//     state=IDLE; BUSY=0, DONE=0, OVERFLOW=0; every HEX digit = 8'hFF (blank).
//   Internal BCD width: IDIG=(WIDTH+2)/3 digits, enough for 2^WIDTH-1.
//   FSM states and transitions:
//     IDLE: START=1 -> latch BIN into shift reg, clear BCD reg, cnt=0, go CONV.
//     CONV: per cycle, add 3 to each BCD nibble >=5, then shift {bcd,shreg} left 1.
//           cnt++; after WIDTH CONV cycles go UPD.
//     UPD: OVERFLOW = any BCD digit index >= DIGITS is nonzero.
//          Load the HEX register; DONE=1 for this cycle; go IDLE.
//   Latency: START accepted at edge 0 -> CONV spans edges 1..WIDTH.
//     DONE and new HEX appear after edge WIDTH+1; 11 cycles for WIDTH=10.
//   BUSY is high in CONV and UPD; low in IDLE.
//   START while BUSY is ignored, not queued. START held high restarts every WIDTH+2 cycles.
//   HEX and OVERFLOW hold the last result while converting; the display never shows partial values.
//   Encoding, active-low:
//     0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90
//     blank=FF, dash=BF; dp is always off (bit7=1).
//   Overflow: all DIGITS digits show dash (BF); OVERFLOW stays 1 until the next UPD.
//   Blanking (BLANK_LZ=1): a digit k>0 is FF if it and all higher displayed digits are 0.
//   RESET_N low mid-conversion: abort immediately to the reset values; no DONE pulse.
//   BIN changing after accept has no effect on the conversion in flight.
// STRUCTURE
//   Include file seg7_defs.vh: SEG_0..SEG_9, SEG_BLANK, SEG_DASH constants.
//   Include file seg7_defs.vh: state encodings S_IDLE/S_CONV/S_UPD.
//   Sub-module seg7_decode: combinational 4-bit BCD -> 8-bit active-low pattern.
//     Generated DIGITS times; non-decimal codes map to SEG_BLANK.
//   Top module holds the FSM, the shift/BCD registers, the blanking and overflow logic,
//   and the HEX output register.
// TESTING (WIDTH=10, DIGITS=4, BLANK_LZ=1 unless noted; HEX listed digit3..digit0)
//   1. Reset: RESET_N=0 -> HEX=FF,FF,FF,FF; BUSY=0; DONE=0; OVERFLOW=0.
//   2. BIN=0, START 1 cycle -> DONE exactly 11 cycles later; HEX=FF,FF,FF,C0.
//   3. BIN=1023 -> HEX=F9,C0,A4,B0 (1023), OVERFLOW=0.
//      Then BIN=7 with BLANK_LZ=0 -> C0,C0,C0,F8.
//   4. DIGITS=3, BIN=1000 -> OVERFLOW=1, HEX=BF,BF,BF.
//      Then BIN=999 -> OVERFLOW=0, HEX=90,90,90.
//   5. START pulsed on cycle 3 of a busy conversion, with BIN changed to 5:
//      -> exactly one DONE pulse, showing the original value.
//   6. RESET_N low at CONV cycle 5 -> outputs return to reset values; no DONE.
//      A new START after release converts correctly.
//   Sweep: BIN=0..1023 against a $display reference model.

Source files
------------

// File: rtl/bcd_seg_display_pkg.sv
// Shared constants for the BCD 7-segment display slice: active-low segment
// patterns, FSM state encoding and the internal BCD digit-count helper.
package bcd_seg_display_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_UPD  = 2'd2
  } state_t;

  // Number of BCD digits needed to hold 2^width-1.
  function automatic int bcd_digits(input int width);
    return (width + 2) / 3;
  endfunction

endpackage

// File: rtl/bcd_seg_display_seg7_decode.sv
// Combinational BCD digit to active-low {dp,g,f,e,d,c,b,a} pattern.
// Codes 10..15 are not decimal and show as blank.
module seg7_decode
  import bcd_seg_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seg_display.sv
// Sequential binary-to-decimal converter (double-dabble, one bit per clock)
// driving DIGITS active-low 7-segment displays with blanking and overflow dashes.
module bcd_seg_display
  import bcd_seg_display_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                MAX10_CLK1_50,
  input  logic                RESET_N,
  input  logic                START,
  input  logic [WIDTH-1:0]    BIN,
  output logic                BUSY,
  output logic                DONE,
  output logic                OVERFLOW,
  output logic [8*DIGITS-1:0] HEX,
  output state_t              dbg_state
);

  localparam int IDIG = bcd_digits(WIDTH);
  localparam int CW   = $clog2(WIDTH + 1);

  // Handshake: START is accepted on any rising edge where the FSM is idle,
  // and BIN is captured on that same edge. BUSY is high while converting,
  // DONE pulses one cycle with HEX/OVERFLOW already holding the new result,
  // and START seen while BUSY is dropped rather than queued.

  state_t              state, state_nx;
  logic [WIDTH-1:0]    shreg;
  logic [4*IDIG-1:0]   bcd, bcd_adj;
  logic [CW-1:0]       cnt;
  logic                last_shift;
  logic                load, shift_en, upd;
  logic                ovf_nx;
  logic [8*DIGITS-1:0] hex_nx;
  logic [3:0]          disp [DIGITS];
  logic [7:0]          seg  [DIGITS];

  assign last_shift = (cnt == CW'(WIDTH - 1));
  assign dbg_state  = state;

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (START) state_nx = S_CONV;
      S_CONV:  if (last_shift) state_nx = S_UPD;
      S_UPD:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY     = (state != S_IDLE);
    load     = (state == S_IDLE) && START;
    shift_en = (state == S_CONV);
    upd      = (state == S_UPD);
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < IDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= BIN;
      bcd   <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      bcd   <= {bcd_adj[4*IDIG-2:0], shreg[WIDTH-1]};
      shreg <= shreg << 1;
      cnt   <= cnt + 1'b1;
    end
  end

  // Digits above the internal BCD width can only ever be zero.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k < IDIG) begin : g_real
      assign disp[k] = bcd[4*k +: 4];
    end else begin : g_pad
      assign disp[k] = 4'd0;
    end
    seg7_decode u_dec (
      .bcd (disp[k]),
      .seg (seg[k])
    );
  end

  always_comb begin
    ovf_nx = 1'b0;
    for (int i = 0; i < IDIG; i++) begin
      if (i >= DIGITS && bcd[4*i +: 4] != 4'd0) ovf_nx = 1'b1;
    end
  end

  // Scan from the top digit down; lz stays set while every digit so far is zero.
  always_comb begin
    logic lz;
    lz     = 1'b1;
    hex_nx = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz = lz && (disp[k] == 4'd0);
      if (ovf_nx)                              hex_nx[8*k +: 8] = SEG_DASH;
      else if (BLANK_LZ != 0 && k > 0 && lz)   hex_nx[8*k +: 8] = SEG_BLANK;
      else                                     hex_nx[8*k +: 8] = seg[k];
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      DONE     <= 1'b0;
      OVERFLOW <= 1'b0;
      HEX      <= '1;
    end else begin
      DONE <= upd;
      if (upd) begin
        OVERFLOW <= ovf_nx;
        HEX      <= hex_nx;
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Bench for bcd_seg_display: three instances (10/4/LZ, 10/4/no-LZ, 10/3/LZ)
// checked against hand vectors and an arithmetic decimal reference model.
module tb_bcd_seg_display;
  import bcd_seg_display_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst_n;

  logic       start_v [3];
  logic [9:0] bin_v   [3];

  logic        busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
  logic [31:0] hex0, hex1;
  logic [23:0] hex2;
  state_t      dbg0, dbg1, dbg2;

  logic        busy_w [3];
  logic        done_w [3];
  logic        ovf_w  [3];
  logic [31:0] hex_w  [3];
  assign busy_w[0] = busy0; assign busy_w[1] = busy1; assign busy_w[2] = busy2;
  assign done_w[0] = done0; assign done_w[1] = done1; assign done_w[2] = done2;
  assign ovf_w[0]  = ovf0;  assign ovf_w[1]  = ovf1;  assign ovf_w[2]  = ovf2;
  assign hex_w[0]  = hex0;  assign hex_w[1]  = hex1;  assign hex_w[2]  = {8'h00, hex2};

  bcd_seg_display #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(1)) u_dut (
    .MAX10_CLK1_50(clk), .RESET_N(rst_n), .START(start_v[0]), .BIN(bin_v[0]),
    .BUSY(busy0), .DONE(done0), .OVERFLOW(ovf0), .HEX(hex0), .dbg_state(dbg0));

  bcd_seg_display #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(0)) u_nolz (
    .MAX10_CLK1_50(clk), .RESET_N(rst_n), .START(start_v[1]), .BIN(bin_v[1]),
    .BUSY(busy1), .DONE(done1), .OVERFLOW(ovf1), .HEX(hex1), .dbg_state(dbg1));

  bcd_seg_display #(.WIDTH(10), .DIGITS(3), .BLANK_LZ(1)) u_d3 (
    .MAX10_CLK1_50(clk), .RESET_N(rst_n), .START(start_v[2]), .BIN(bin_v[2]),
    .BUSY(busy2), .DONE(done2), .OVERFLOW(ovf2), .HEX(hex2), .dbg_state(dbg2));

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_ovf(input int v, input int digits);
    int p = 1;
    for (int i = 0; i < digits; i++) p *= 10;
    return v >= p;
  endfunction

  function automatic logic [31:0] model_hex(input int v, input int digits, input bit blz);
    logic [31:0] h = '0;
    int p = 1;
    for (int k = 0; k < digits; k++) begin
      if (model_ovf(v, digits))      h[8*k +: 8] = 8'hBF;
      else if (blz && k > 0 && v < p) h[8*k +: 8] = 8'hFF;
      else                            h[8*k +: 8] = seg_tab[(v / p) % 10];
      p *= 10;
    end
    return h;
  endfunction

  // ---------------- driver ----------------
  task automatic run_conv(input int d, input logic [9:0] v, input logic [31:0] ehex,
                          input logic eovf, input string tag);
    int lat;
    @(negedge clk); start_v[d] = 1'b1; bin_v[d] = v;
    @(negedge clk); start_v[d] = 1'b0; bin_v[d] = ~v;
    check({tag, " busy"}, 32'(busy_w[d]), 32'd1);
    lat = 0;
    while (!done_w[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 32'd11);
    exp_q.push_back(ehex);
    check({tag, " hex"}, hex_w[d], exp_q.pop_front());
    check({tag, " ovf"}, 32'(ovf_w[d]), 32'(eovf));
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done_w[d]), 32'd0);
  endtask

  function automatic int model_of(input int d, input int v, output logic ovf);
    int digits = (d == 2) ? 3 : 4;
    ovf = model_ovf(v, digits);
    return int'(model_hex(v, digits, d != 1));
  endfunction

  typedef struct {
    logic [9:0]  bin;
    logic [31:0] hex;
    logic        ovf;
  } vec_t;

  vec_t tab [8];

  initial begin
    int   n_done, t1, t2;
    logic [31:0] seen_hex, prev_hex, eh;
    logic eo;

    tab[0] = '{10'd0,    32'hFFFFFFC0, 1'b0};
    tab[1] = '{10'd1023, 32'hF9C0A4B0, 1'b0};
    tab[2] = '{10'd7,    32'hFFFFFFF8, 1'b0};
    tab[3] = '{10'd10,   32'hFFFFF9C0, 1'b0};
    tab[4] = '{10'd100,  32'hFFF9C0C0, 1'b0};
    tab[5] = '{10'd1000, 32'hF9C0C0C0, 1'b0};
    tab[6] = '{10'd58,   32'hFFFF9280, 1'b0};
    tab[7] = '{10'd509,  32'hFF92C090, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin start_v[i] = 1'b0; bin_v[i] = '0; end
    repeat (3) @(negedge clk);

    check("reset hex0", hex0, 32'hFFFFFFFF);
    check("reset hex1", hex1, 32'hFFFFFFFF);
    check("reset hex2", {8'h00, hex2}, 32'h00FFFFFF);
    check("reset busy", {busy0, busy1, busy2}, 32'd0);
    check("reset done", {done0, done1, done2}, 32'd0);
    check("reset ovf",  {ovf0, ovf1, ovf2}, 32'd0);
    check("reset state", 32'(dbg0), 32'(S_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_conv(0, tab[i].bin, tab[i].hex, tab[i].ovf, $sformatf("tab%0d", i));

    run_conv(1, 10'd7,    32'hC0C0C0F8, 1'b0, "nolz 7");
    run_conv(1, 10'd0,    32'hC0C0C0C0, 1'b0, "nolz 0");
    run_conv(2, 10'd1000, 32'h00BFBFBF, 1'b1, "d3 1000");
    run_conv(2, 10'd999,  32'h00909090, 1'b0, "d3 999");

    // START during a busy conversion must be ignored.
    prev_hex = hex0;
    @(negedge clk); start_v[0] = 1'b1; bin_v[0] = 10'd321;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("hold while busy", hex0, prev_hex);
    start_v[0] = 1'b1; bin_v[0] = 10'd5;
    @(negedge clk); start_v[0] = 1'b0;
    n_done = 0; seen_hex = '0;
    for (int c = 0; c < 25; c++) begin
      if (done0) begin n_done++; seen_hex = hex0; end
      @(negedge clk);
    end
    check("busy start pulses", n_done, 32'd1);
    check("busy start hex", seen_hex, 32'hFFB0A4F9);

    // START held high restarts every WIDTH+2 cycles.
    start_v[0] = 1'b1; bin_v[0] = 10'd200;
    t1 = 0;
    while (!done0 && t1 < 40) begin @(negedge clk); t1++; end
    @(negedge clk);
    t2 = 1;
    while (!done0 && t2 < 40) begin @(negedge clk); t2++; end
    start_v[0] = 1'b0;
    check("restart interval", t2, 32'd12);
    check("restart hex", hex0, 32'hFFA4C0C0);
    repeat (14) @(negedge clk);

    // Reset in the middle of a conversion, with an overflow showing on d3.
    run_conv(2, 10'd1001, 32'h00BFBFBF, 1'b1, "d3 1001");
    @(negedge clk); start_v[0] = 1'b1; start_v[2] = 1'b1;
    bin_v[0] = 10'd456; bin_v[2] = 10'd456;
    @(negedge clk); start_v[0] = 1'b0; start_v[2] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort hex0", hex0, 32'hFFFFFFFF);
    check("abort busy", 32'(busy0), 32'd0);
    check("abort ovf2", 32'(ovf2), 32'd0);
    check("abort hex2", {8'h00, hex2}, 32'h00FFFFFF);
    @(negedge clk); rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      if (done0 || done2) n_done++;
      @(negedge clk);
    end
    check("abort no done", n_done, 32'd0);
    run_conv(0, 10'd88, 32'hFFFF8080, 1'b0, "after abort");

    // Full sweep on the main instance against the model.
    for (int v = 0; v < 1024; v++) begin
      eh = 32'(model_of(0, v, eo));
      run_conv(0, 10'(v), eh, eo, $sformatf("sweep %0d", v));
    end

    // Random values on the other two configurations.
    for (int i = 0; i < 150; i++) begin
      int v1, v2;
      v1 = $urandom_range(0, 1023);
      eh = 32'(model_of(1, v1, eo));
      run_conv(1, 10'(v1), eh, eo, $sformatf("rand nolz %0d", v1));
      v2 = $urandom_range(900, 1023);
      if ((i % 3) == 0) v2 = $urandom_range(0, 1023);
      eh = 32'(model_of(2, v2, eo));
      run_conv(2, 10'(v2), eh, eo, $sformatf("rand d3 %0d", v2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
